// File: rtl/uart_pkg.sv
// Shared FSM types and constants for the command UART front end.
package uart_pkg;
   localparam int DATA_BITS = 8;
   localparam int BAUD_MIN  = 16;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic       {EXPECT_HI, EXPECT_LO} asm_state_t;
endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM, single-cycle
// byte-valid / framing-error strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_i,
   input  logic [BAUD_W-1:0] per_i,
   output logic [7:0]        rx_byte_o,
   output logic              rx_vld_o,
   output logic              rx_ferr_o,
   output logic              rx_start_o,
   output logic              rx_busy_o
);
   localparam logic [BAUD_W-1:0] CNT_ONE = BAUD_W'(1);

   logic                 rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_t            state_q;
   logic [BAUD_W-1:0]    cnt_q, per_q;
   logic [2:0]           bit_q;
   logic [DATA_BITS-1:0] sh_q;
   logic                 bit_end;

   assign bit_end    = (cnt_q == per_q);
   assign rx_start_o = (state_q == RX_IDLE) && rx_prev_q && !rx_s2_q;
   assign rx_vld_o   = (state_q == RX_STOP) && bit_end && rx_s2_q;
   assign rx_ferr_o  = (state_q == RX_STOP) && bit_end && !rx_s2_q;
   assign rx_byte_o  = sh_q;
   assign rx_busy_o  = (state_q != RX_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         per_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
      end else begin
         rx_s1_q   <= rx_i;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         case (state_q)
            RX_IDLE: begin
               // Period is frozen here so a baud change cannot corrupt a frame.
               if (rx_start_o) begin
                  state_q <= RX_START;
                  cnt_q   <= CNT_ONE;
                  per_q   <= per_i;
               end
            end
            RX_START: begin
               if (cnt_q == (per_q >> 1)) begin
                  cnt_q   <= CNT_ONE;
                  bit_q   <= '0;
                  state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            RX_DATA: begin
               if (bit_end) begin
                  cnt_q <= CNT_ONE;
                  sh_q  <= {rx_s2_q, sh_q[DATA_BITS-1:1]};
                  bit_q <= bit_q + 3'd1;
                  if (bit_q == 3'(DATA_BITS - 1)) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            RX_STOP: begin
               if (bit_end) state_q <= RX_IDLE;
               else         cnt_q   <= cnt_q + CNT_ONE;
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: rtl/cmd_uart_if.sv
// UART command front end: pairs received bytes into 16-bit commands and
// serializes response bytes. Define CMD_TIMEOUT_EN to drop a stale high byte.
module cmd_uart_if
   import uart_pkg::*;
#(
   parameter int BAUD_W  = 16,
   parameter int TO_BITS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RX,
   output logic              TX,
   input  logic [BAUD_W-1:0] baud_cnt,
   output logic [15:0]       cmd,
   output logic              cmd_rdy,
   input  logic              clr_cmd_rdy,
   input  logic [7:0]        resp,
   input  logic              send_resp,
   output logic              resp_sent
);
   localparam logic [BAUD_W-1:0] CNT_ONE = BAUD_W'(1);

   logic [BAUD_W-1:0] per_eff;
   logic [7:0]        rx_byte;
   logic              rx_vld, rx_ferr, rx_start, rx_busy;
   logic              asm_timeout;

   assign per_eff = (baud_cnt < BAUD_W'(BAUD_MIN)) ? BAUD_W'(BAUD_MIN) : baud_cnt;

   uart_rx #(.BAUD_W(BAUD_W)) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_i      (RX),
      .per_i     (per_eff),
      .rx_byte_o (rx_byte),
      .rx_vld_o  (rx_vld),
      .rx_ferr_o (rx_ferr),
      .rx_start_o(rx_start),
      .rx_busy_o (rx_busy)
   );

   asm_state_t asm_q;
   logic [15:0] cmd_q;
   logic        cmd_rdy_q;

`ifdef CMD_TIMEOUT_EN
   logic [31:0] to_cnt_q;
   logic [31:0] to_limit;

   assign to_limit    = 32'(TO_BITS) * 32'(per_eff);
   assign asm_timeout = (asm_q == EXPECT_LO) && !rx_busy && !rx_start &&
                        (to_cnt_q >= to_limit - 32'd1);

   // Counts line-idle cycles only; any start edge restarts the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         to_cnt_q <= '0;
      else if (asm_q != EXPECT_LO || rx_start || rx_busy) to_cnt_q <= '0;
      else                                                to_cnt_q <= to_cnt_q + 32'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^{rx_start, rx_busy, 32'(TO_BITS)};
   assign asm_timeout    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q     <= EXPECT_HI;
         cmd_q     <= '0;
         cmd_rdy_q <= 1'b0;
      end else begin
         if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
         // Bytes arriving while the consumer still owns cmd are dropped.
         if (rx_vld && !cmd_rdy_q && !clr_cmd_rdy) begin
            if (asm_q == EXPECT_HI) begin
               cmd_q[15:8] <= rx_byte;
               asm_q       <= EXPECT_LO;
            end else begin
               cmd_q[7:0]  <= rx_byte;
               cmd_rdy_q   <= 1'b1;
               asm_q       <= EXPECT_HI;
            end
         end else if ((rx_ferr || asm_timeout) && asm_q == EXPECT_LO) begin
            asm_q <= EXPECT_HI;
         end
      end
   end

   tx_state_t         tx_state_q;
   logic [BAUD_W-1:0] tx_cnt_q, tx_per_q;
   logic [2:0]        tx_bit_q;
   logic [7:0]        tx_sh_q;
   logic              tx_q, resp_sent_q;
   logic              tx_bit_end;

   assign tx_bit_end = (tx_cnt_q == tx_per_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_per_q    <= '0;
         tx_bit_q    <= '0;
         tx_sh_q     <= '0;
         tx_q        <= 1'b1;
         resp_sent_q <= 1'b0;
      end else begin
         resp_sent_q <= 1'b0;
         if (tx_state_q != TX_IDLE) tx_cnt_q <= tx_bit_end ? CNT_ONE : tx_cnt_q + CNT_ONE;
         case (tx_state_q)
            TX_IDLE: begin
               if (send_resp) begin
                  tx_state_q <= TX_START;
                  tx_q       <= 1'b0;
                  tx_cnt_q   <= CNT_ONE;
                  tx_per_q   <= per_eff;
                  tx_sh_q    <= resp;
               end
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_state_q <= TX_DATA;
                  tx_q       <= tx_sh_q[0];
                  tx_bit_q   <= '0;
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_bit_q <= tx_bit_q + 3'd1;
                  if (tx_bit_q == 3'(DATA_BITS - 1)) begin
                     tx_state_q <= TX_STOP;
                     tx_q       <= 1'b1;
                  end else begin
                     tx_sh_q <= {1'b0, tx_sh_q[7:1]};
                     tx_q    <= tx_sh_q[1];
                  end
               end
            end
            TX_STOP: begin
               if (tx_bit_end) begin
                  tx_state_q  <= TX_IDLE;
                  resp_sent_q <= 1'b1;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   assign TX        = tx_q;
   assign cmd       = cmd_q;
   assign cmd_rdy   = cmd_rdy_q;
   assign resp_sent = resp_sent_q;
endmodule
